// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential segmented adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  function automatic int nseg(input int n, input int seg);
    return n / seg;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry slice; masked bits are OR-approximated and
// hand a&b of themselves on as carry, so the topmost masked bit sets the carry out.
module rca_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic [SEG-1:0] approx_mask,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] c;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int j = 0; j < SEG; j++) begin
      if (approx_mask[j]) begin
        s[j]     = a[j] | b[j];
        c[j + 1] = a[j] & b[j];
      end else begin
        s[j]     = a[j] ^ b[j] ^ c[j];
        c[j + 1] = (a[j] & b[j]) | (c[j] & (a[j] ^ b[j]));
      end
    end
    cout = c[SEG];
  end

endmodule

// File: rtl/seq_segmented_adder.sv
// Multi-cycle segmented adder with exact / lower-part-OR modes and valid/ready on both sides.
// Define ADDER_ERR_STATS_EN to add Err_flag / Err_count against a shadow exact sum.
module seq_segmented_adder
  import adder_pkg::*;
#(
  parameter int N           = 16,
  parameter int SEG         = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Mode,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout
`ifdef ADDER_ERR_STATS_EN
  ,
  output logic         Err_flag,
  output logic [15:0]  Err_count
`endif
);

  localparam int NSEG  = nseg(N, SEG);
  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  generate
    if ((N % SEG) != 0 || APPROX_BITS > N || APPROX_BITS < 0) begin : g_bad_cfg
      $error("seq_segmented_adder: N must be a multiple of SEG and APPROX_BITS within 0..N");
    end
  endgenerate

  state_t           state_q, state_d;
  logic             accept;
  logic [N-1:0]     a_q, b_q;
  logic             mode_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [SEG-1:0]   seg_a, seg_b, seg_mask, seg_s;
  logic             seg_cout;

  // In DONE the next operands may be taken in the same cycle the result leaves.
  always_comb begin
    state_d  = state_q;
    In_ready = 1'b0;
    case (state_q)
      IDLE: In_ready = 1'b1;
      DONE: In_ready = Out_ready;
      default: In_ready = 1'b0;
    endcase
    accept = In_valid && In_ready;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (idx_q == LAST_IDX) state_d = DONE;
      DONE: begin
        if (accept)         state_d = BUSY;
        else if (Out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The approximation mask is per absolute bit, so it can straddle segments.
  always_comb begin
    seg_a    = '0;
    seg_b    = '0;
    seg_mask = '0;
    for (int s = 0; s < NSEG; s++) begin
      if (idx_q == IDX_W'(s)) begin
        seg_a = a_q[s*SEG +: SEG];
        seg_b = b_q[s*SEG +: SEG];
      end
    end
    for (int j = 0; j < SEG; j++) begin
      seg_mask[j] = (mode_q == MODE_APPROX) && ((int'(idx_q) * SEG + j) < APPROX_BITS);
    end
  end

  rca_segment #(.SEG(SEG)) u_seg (
    .a           (seg_a),
    .b           (seg_b),
    .cin         (carry_q),
    .approx_mask (seg_mask),
    .s           (seg_s),
    .cout        (seg_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_EXACT;
      carry_q <= 1'b0;
      idx_q   <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      mode_q  <= Mode;
      carry_q <= Cin;
      idx_q   <= '0;
    end else if (state_q == BUSY) begin
      for (int s = 0; s < NSEG; s++) begin
        if (idx_q == IDX_W'(s)) Sum[s*SEG +: SEG] <= seg_s;
      end
      carry_q <= seg_cout;
      idx_q   <= idx_q + 1'b1;
      if (idx_q == LAST_IDX) Cout <= seg_cout;
    end
  end

  assign Out_valid = (state_q == DONE);

`ifdef ADDER_ERR_STATS_EN
  logic [N:0] exact_q;

  assign Err_flag = Out_valid && ({Cout, Sum} != exact_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      exact_q   <= '0;
      Err_count <= '0;
    end else begin
      if (accept) exact_q <= {1'b0, A} + {1'b0, B} + (N + 1)'(Cin);
      if (Out_valid && Out_ready && Err_flag && Err_count != 16'hFFFF)
        Err_count <= Err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_segmented_adder.sv
// Scoreboard bench for seq_segmented_adder (N=16, SEG=4, APPROX_BITS=4).
module tb_seq_segmented_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        In_valid, In_ready;
  logic [15:0] A, B;
  logic        Cin, Mode;
  logic        Out_valid, Out_ready;
  logic [15:0] Sum;
  logic        Cout;
`ifdef ADDER_ERR_STATS_EN
  logic        Err_flag;
  logic [15:0] Err_count;
  int          err_cnt_model = 0;
`endif

  typedef struct {
    logic [16:0] res;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_segmented_adder #(.N(16), .SEG(4), .APPROX_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Mode      (Mode),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
`ifdef ADDER_ERR_STATS_EN
    ,
    .Err_flag  (Err_flag),
    .Err_count (Err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] exact_sum(input logic [15:0] a, b, input logic cin);
    return {1'b0, a} + {1'b0, b} + 17'(cin);
  endfunction

  function automatic logic [16:0] model(input logic [15:0] a, b, input logic cin, mode);
    logic [12:0] hi;
    if (!mode) return exact_sum(a, b, cin);
    hi = 13'(a[15:4]) + 13'(b[15:4]) + 13'(a[3] & b[3]);
    return {hi, a[3:0] | b[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, b, input logic cin, mode);
    exp_t e;
    e.res = model(a, b, cin, mode);
    e.err = (e.res != exact_sum(a, b, cin));
    sb_q.push_back(e);
  endtask

  // Pops the head of the scoreboard and compares it to the visible result.
  task automatic compare_head(input string name);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: result {Cout,Sum}=%h with empty scoreboard", name, {Cout, Sum});
      return;
    end
    e = sb_q.pop_front();
    if ({Cout, Sum} !== e.res) begin
      n_fail++;
      $display("FAIL %s: {Cout,Sum}=%h expected %h", name, {Cout, Sum}, e.res);
    end
`ifdef ADDER_ERR_STATS_EN
    n_checks++;
    if (Err_flag !== e.err) begin
      n_fail++;
      $display("FAIL %s_err_flag: Err_flag=%b expected %b", name, Err_flag, e.err);
    end
    if (e.err && err_cnt_model != 16'hFFFF) err_cnt_model++;
`endif
  endtask

  task automatic send(input logic [15:0] a, b, input logic cin, mode);
    int guard = 0;
    A = a; B = b; Cin = cin; Mode = mode; In_valid = 1'b1;
    while (!In_ready && guard < 50) begin step(); guard++; end
    if (!In_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: In_ready=%b expected 1", In_ready);
      In_valid = 1'b0;
      return;
    end
    push_exp(a, b, cin, mode);
    step();
    In_valid = 1'b0;
    A = $urandom; B = $urandom; Mode = $urandom;
  endtask

  // Called one cycle after the accepting edge; expects Out_valid after exactly 4 edges.
  task automatic get_result(input string name);
    int cyc = 0;
    while (!Out_valid && cyc < 20) begin step(); cyc++; end
    n_checks++;
    if (!Out_valid || cyc != 4) begin
      n_fail++;
      $display("FAIL %s_latency: cycles=%0d Out_valid=%b expected 4 and 1", name, cyc, Out_valid);
      return;
    end
    compare_head(name);
    Out_ready = 1'b1;
    step();
    Out_ready = 1'b0;
`ifdef ADDER_ERR_STATS_EN
    n_checks++;
    if (Err_count !== 16'(err_cnt_model)) begin
      n_fail++;
      $display("FAIL %s_err_count: Err_count=%0d expected %0d", name, Err_count, err_cnt_model);
    end
`endif
  endtask

  task automatic check_idle_reset(input string name);
    n_checks++;
    if (Out_valid !== 1'b0 || Sum !== 16'h0 || Cout !== 1'b0 || In_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: Out_valid=%b Sum=%h Cout=%b In_ready=%b expected 0 0000 0 1",
               name, Out_valid, Sum, Cout, In_ready);
    end
`ifdef ADDER_ERR_STATS_EN
    n_checks++;
    if (Err_count !== 16'h0 || Err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_stats: Err_count=%0d Err_flag=%b expected 0 0", name, Err_count, Err_flag);
    end
    err_cnt_model = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    check_idle_reset("reset_values");
    rst = 1'b0;
    step();
    check_idle_reset("after_reset_release");
  endtask

  task automatic test_exact_wrap();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    get_result("exact_wrap");
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    get_result("exact_cin");
  endtask

  task automatic test_approx_no_carry();
    send(16'h000F, 16'h0001, 1'b0, 1'b1);
    get_result("approx_no_carry");
  endtask

  task automatic test_approx_gen_carry();
    send(16'h0008, 16'h0008, 1'b1, 1'b1);
    get_result("approx_gen_carry");
    send(16'hFFFF, 16'h0008, 1'b0, 1'b1);
    get_result("approx_carry_wrap");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   cyc = 0;
    send(16'h0102, 16'h0304, 1'b0, 1'b0);
    while (!Out_valid && cyc < 20) begin step(); cyc++; end
    n_checks++;
    if (!Out_valid || cyc != 4 || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL bp_latency: cycles=%0d Out_valid=%b expected 4 and 1", cyc, Out_valid);
      return;
    end
    e = sb_q[0];
    for (int k = 0; k < 5; k++) begin
      A = $urandom; B = $urandom; Mode = $urandom;
      #1;
      n_checks++;
      if ({Cout, Sum} !== e.res || In_ready !== 1'b0 || Out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: {Cout,Sum}=%h In_ready=%b Out_valid=%b expected %h 0 1",
                 k, {Cout, Sum}, In_ready, Out_valid, e.res);
      end
      step();
    end
    A = 16'h1234; B = 16'h1111; Cin = 1'b0; Mode = 1'b0;
    In_valid = 1'b1; Out_ready = 1'b1;
    #1;
    n_checks++;
    if (In_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_in_ready: In_ready=%b expected 1", In_ready);
    end
    compare_head("bp_held_result");
    push_exp(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    In_valid = 1'b0; Out_ready = 1'b0;
    n_checks++;
    if (Out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_busy: Out_valid=%b expected 0", Out_valid);
    end
    get_result("bp_next");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send(16'hABCD, 16'h1111, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb_q.pop_back());
    check_idle_reset("reset_mid");
    for (int k = 0; k < 8; k++) begin
      if (Out_valid) seen++;
      step();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_result: Out_valid cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] op_a[8], op_b[8];
    logic        op_c[8], op_m[8];
    int sent = 0, got = 0, cyc = 0, last = -1;
    for (int i = 0; i < 8; i++) begin
      op_a[i] = 16'($urandom); op_b[i] = 16'($urandom);
      op_c[i] = 1'($urandom);  op_m[i] = 1'(i % 2);
    end
    A = op_a[0]; B = op_b[0]; Cin = op_c[0]; Mode = op_m[0];
    In_valid = 1'b1; Out_ready = 1'b1;
    #1;
    while (got < 8 && cyc < 200) begin
      if (Out_valid) begin
        compare_head($sformatf("b2b_%0d", got));
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing_%0d: interval=%0d expected 5", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (In_valid && In_ready) begin
        push_exp(A, B, Cin, Mode);
        sent++;
      end
      step();
      cyc++;
      if (sent < 8) begin
        A = op_a[sent]; B = op_b[sent]; Cin = op_c[sent]; Mode = op_m[sent];
      end else begin
        In_valid = 1'b0;
      end
    end
    Out_ready = 1'b0;
    n_checks++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL b2b_timeout: results=%0d expected 8", got);
    end
  endtask

  initial begin
    rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Mode = 1'b0;
    test_reset();
    test_exact_wrap();
    test_approx_no_carry();
    test_approx_gen_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
